// File: rtl/crc_stream_encoder.sv
// Serial USB CRC encoder: PID then payload LSB-first, then complemented CRC MSB-first.
// Latency: the first bit is valid the cycle after acceptance; one bit per completed beat.
// Backpressure: bs_ready low holds out_bit, out_last, the state, the counter and the CRC; pkt_ready only in IDLE.
module crc_stream_encoder #(
    parameter int                 PKT_W = 72,
    parameter int                 PID_W = 8,
    parameter int                 CRC_W = 16,
    parameter logic [CRC_W-1:0]   POLY  = 16'h8005,
    parameter int                 LEN_W = $clog2(PKT_W-PID_W+1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pkt_valid,
    output logic             pkt_ready,
    input  logic [PKT_W-1:0] pkt_in,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic             crc_en,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    input  logic             bs_ready,
    output logic             busy
);

    localparam int PAY_W = PKT_W - PID_W;
    localparam int MAX_A = (PID_W > PAY_W) ? PID_W : PAY_W;
    localparam int MAX_N = (MAX_A > CRC_W) ? MAX_A : CRC_W;
    localparam int CNT_W = $clog2(MAX_N + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND_PID,
        SEND_DATA,
        SEND_CRC
    } state_t;

    state_t             state, state_nxt;
    logic [PKT_W-1:0]   shift_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_clamped;
    logic               crc_en_q;
    logic [CRC_W-1:0]   crc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept, beat;
    logic               last_pid, last_data, last_crc;
    logic               crc_bit, fb;

    assign pkt_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign out_valid   = (state != IDLE);
    assign accept      = pkt_valid & pkt_ready;
    assign beat        = out_valid & bs_ready;
    assign len_clamped = (int'(pkt_len) > PAY_W) ? LEN_W'(PAY_W) : pkt_len;

    assign last_pid  = (int'(cnt_q) == PID_W - 1);
    assign last_data = (int'(cnt_q) == int'(len_q) - 1);
    assign last_crc  = (int'(cnt_q) == CRC_W - 1);
    assign fb        = shift_q[0] ^ crc_q[CRC_W-1];

    // CRC field goes out MSB-first and inverted; the register itself stays frozen.
    always_comb begin
        crc_bit = 1'b0;
        for (int i = 0; i < CRC_W; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                crc_bit = ~crc_q[CRC_W-1-i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SEND_PID;
                end
            end
            SEND_PID: begin
                out_bit = shift_q[0];
                if (last_pid) begin
                    out_last = (len_q == '0) & ~crc_en_q;
                    if (beat) begin
                        if (len_q != '0) begin
                            state_nxt = SEND_DATA;
                        end else if (crc_en_q) begin
                            state_nxt = SEND_CRC;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            SEND_DATA: begin
                out_bit = shift_q[0];
                if (last_data) begin
                    out_last = ~crc_en_q;
                    if (beat) begin
                        state_nxt = crc_en_q ? SEND_CRC : IDLE;
                    end
                end
            end
            SEND_CRC: begin
                out_bit  = crc_bit;
                out_last = last_crc;
                if (beat && last_crc) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q  <= '0;
            len_q    <= '0;
            crc_en_q <= 1'b0;
            crc_q    <= '1;
            cnt_q    <= '0;
        end else if (accept) begin
            shift_q  <= pkt_in;
            len_q    <= len_clamped;
            crc_en_q <= crc_en;
            crc_q    <= '1;
            cnt_q    <= '0;
        end else if (beat) begin
            // Every state change restarts the shared beat counter.
            cnt_q <= (state_nxt != state) ? '0 : cnt_q + CNT_W'(1);
            if (state == SEND_PID || state == SEND_DATA) begin
                shift_q <= shift_q >> 1;
            end
            if (state == SEND_DATA) begin
                crc_q <= {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_encoder.sv
// Scoreboard bench: a 72-bit CRC16 instance and a 19-bit CRC5 token instance.
module tb_crc_stream_encoder;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset_n;

    logic        m_pv, m_pr, m_ce, m_ob, m_ov, m_ol, m_br, m_busy;
    logic [71:0] m_pin;
    logic [6:0]  m_len;
    logic        t_pv, t_pr, t_ce, t_ob, t_ov, t_ol, t_br, t_busy;
    logic [18:0] t_pin;
    logic [3:0]  t_len;

    crc_stream_encoder #(.PKT_W(72), .PID_W(8), .CRC_W(16), .POLY(16'h8005)) dut_main (
        .clock(clock), .reset_n(reset_n), .pkt_valid(m_pv), .pkt_ready(m_pr),
        .pkt_in(m_pin), .pkt_len(m_len), .crc_en(m_ce), .out_bit(m_ob),
        .out_valid(m_ov), .out_last(m_ol), .bs_ready(m_br), .busy(m_busy)
    );

    crc_stream_encoder #(.PKT_W(19), .PID_W(8), .CRC_W(5), .POLY(5'h05)) dut_tok (
        .clock(clock), .reset_n(reset_n), .pkt_valid(t_pv), .pkt_ready(t_pr),
        .pkt_in(t_pin), .pkt_len(t_len), .crc_en(t_ce), .out_bit(t_ob),
        .out_valid(t_ov), .out_last(t_ol), .bs_ready(t_br), .busy(t_busy)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [1:0] exp_q0[$];
    logic [1:0] exp_q1[$];
    bit   stall_en = 1'b0;
    int   beat_idx = 0;
    int   last_idx = -1;
    int   hold_cnt = 0;
    bit   prev_stall[2];
    logic [1:0] prev_val[2];
    bit   chk_gap[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: CRC as remainder of polynomial long division, init ones folded into the dividend.
    task automatic model_push(input int inst, input logic [71:0] pkt, input int len, input bit ce);
        int crcw;
        int maxpay;
        logic [15:0] poly;
        int n;
        int d[0:127];
        bit seq[$];
        crcw   = (inst == 0) ? 16 : 5;
        maxpay = (inst == 0) ? 64 : 11;
        poly   = (inst == 0) ? 16'h8005 : 16'h0005;
        n      = (len > maxpay) ? maxpay : len;
        for (int i = 0; i < 8 + n; i++) seq.push_back(pkt[i]);
        if (ce) begin
            for (int i = 0; i < n + crcw; i++) d[i] = (i < n) ? int'(pkt[8+i]) : 0;
            for (int i = 0; i < crcw; i++) d[i] ^= 1;
            for (int i = 0; i < n; i++) begin
                if (d[i] != 0) begin
                    d[i] = 0;
                    for (int j = 1; j <= crcw; j++) d[i+j] ^= int'(poly[crcw-j]);
                end
            end
            for (int k = 0; k < crcw; k++) seq.push_back(d[n+k] == 0);
        end
        for (int i = 0; i < seq.size(); i++) begin
            if (inst == 0) exp_q0.push_back({seq[i], i == seq.size() - 1});
            else           exp_q1.push_back({seq[i], i == seq.size() - 1});
        end
    endtask

    task automatic mon(input int i, input logic ov, input logic ob, input logic ol,
                       input logic br, input logic pr);
        logic [1:0] e;
        bit empty;
        if (chk_gap[i]) begin
            chk_gap[i] = 1'b0;
            chk("gap_pkt_ready", 32'(pr), 32'd1);
            chk("gap_out_valid", 32'(ov), 32'd0);
        end
        if (prev_stall[i] && ov) chk("stall_hold", 32'({ob, ol}), 32'(prev_val[i]));
        prev_stall[i] = ov && !br;
        prev_val[i]   = {ob, ol};
        if (ov && br) begin
            empty = (i == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
            if (empty) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_beat inst%0d: got bit %b, required no output", i, ob);
            end else begin
                e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk((i == 0) ? "main_beat{bit,last}" : "tok_beat{bit,last}", 32'({ob, ol}), 32'(e));
                if (e[0]) chk_gap[i] = 1'b1;
                if (i == 0) beat_idx = e[0] ? 0 : beat_idx + 1;
            end
        end
    endtask

    always @(negedge clock) begin
        mon(0, m_ov, m_ob, m_ol, m_br, m_pr);
        mon(1, t_ov, t_ob, t_ol, t_br, t_pr);
    end

    // Forced stalls on the last PID beat, last data beat and first CRC beat of 64-bit payloads.
    always @(posedge clock) begin
        #1;
        if (beat_idx != last_idx) begin
            last_idx = beat_idx;
            hold_cnt = 0;
        end
        if (stall_en && (beat_idx == 7 || beat_idx == 71 || beat_idx == 72) && hold_cnt < 3) begin
            m_br = 1'b0;
            hold_cnt++;
        end else begin
            m_br = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic send_main(input logic [71:0] pkt, input int len, input bit ce);
        int w = 0;
        while (!m_pr && w < 2000) begin @(posedge clock); #1; w++; end
        if (!m_pr) begin
            n_cmp++; n_fail++;
            $display("FAIL send_main_timeout: pkt_ready 0, required 1");
        end
        model_push(0, pkt, len, ce);
        m_pin = pkt; m_len = 7'(len); m_ce = ce; m_pv = 1'b1;
        @(posedge clock); #1;
        m_pv = 1'b0;
    endtask

    task automatic send_tok(input logic [18:0] pkt, input int len, input bit ce);
        int w = 0;
        while (!t_pr && w < 2000) begin @(posedge clock); #1; w++; end
        if (!t_pr) begin
            n_cmp++; n_fail++;
            $display("FAIL send_tok_timeout: pkt_ready 0, required 1");
        end
        model_push(1, 72'(pkt), len, ce);
        t_pin = pkt; t_len = 4'(len); t_ce = ce; t_pv = 1'b1;
        @(posedge clock); #1;
        t_pv = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || !m_pr || !t_pr) && w < 5000) begin
            @(posedge clock); #1; w++;
        end
        if (w >= 5000) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: %0d/%0d beats still expected, required 0",
                     exp_q0.size(), exp_q1.size());
        end
        @(posedge clock); #1;
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation still running, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        m_pv = 0; m_pin = '0; m_len = '0; m_ce = 0; m_br = 1;
        t_pv = 0; t_pin = '0; t_len = '0; t_ce = 0; t_br = 1;
        reset_n = 1'b0;
        #2;
        chk("rst_pkt_ready", 32'(m_pr), 32'd1);
        chk("rst_out_valid", 32'(m_ov), 32'd0);
        chk("rst_out_bit",   32'(m_ob), 32'd0);
        chk("rst_out_last",  32'(m_ol), 32'd0);
        chk("rst_busy",      32'(m_busy), 32'd0);
        chk("rst_tok_ready", 32'(t_pr), 32'd1);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;

        send_main(72'hD2, 0, 1'b0);                           // handshake
        drain();
        send_tok({11'd0, 8'h2D}, 11, 1'b1);                   // SETUP addr 0 ep 0
        drain();
        send_main(72'hC3, 0, 1'b1);                           // zero-length DATA0
        drain();
        send_main({64'h0706050403020100, 8'hC3}, 64, 1'b1);
        drain();
        stall_en = 1'b1;
        send_main({64'h0706050403020100, 8'hC3}, 64, 1'b1);
        drain();
        stall_en = 1'b0;

        send_main(72'({$urandom, $urandom, $urandom}), 100, 1'b1);
        chk("busy_after_accept", 32'(m_busy), 32'd1);
        for (int i = 0; i < 20; i++) begin
            m_pv = 1'b1;
            m_pin = 72'({$urandom, $urandom, $urandom});
            m_len = 7'($urandom_range(0, 127));
            m_ce = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
        end
        m_pv = 1'b0;
        drain();

        for (int i = 0; i < 10; i++) begin
            stall_en = 1'($urandom_range(0, 1));
            send_main(72'({$urandom, $urandom, $urandom}), int'($urandom_range(0, 80)),
                      1'($urandom_range(0, 1)));
            send_tok(19'($urandom), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            drain();
        end
        stall_en = 1'b0;

        send_main(72'({$urandom, $urandom, $urandom}), 64, 1'b1);
        repeat (20) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(m_ov), 32'd0);
        chk("midrst_out_bit",   32'(m_ob), 32'd0);
        chk("midrst_out_last",  32'(m_ol), 32'd0);
        chk("midrst_pkt_ready", 32'(m_pr), 32'd1);
        chk("midrst_busy",      32'(m_busy), 32'd0);
        exp_q0.delete();
        beat_idx = 0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        send_main(72'({$urandom, $urandom, $urandom}), 40, 1'b1);
        drain();
        send_main({64'h0706050403020100, 8'hC3}, 64, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
